// File: rtl/cache_profile_reporter.sv
// cache_profile_reporter: snapshots six 32-bit cache profiler counters on a
// trigger rising edge and streams them as a 26-byte frame
// (header, 24 payload bytes MSB-first, XOR checksum) over a valid/ready byte port.
module cache_profile_reporter #(
   parameter logic [7:0]  HEADER_BYTE = 8'hA5,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             trigger,
   input  logic [31:0]      icache_request_counter,
   input  logic [31:0]      icache_hit_counter,
   input  logic [31:0]      icache_miss_counter,
   input  logic [31:0]      dcache_request_counter,
   input  logic [31:0]      dcache_hit_counter,
   input  logic [31:0]      dcache_miss_counter,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] dropped_count
);

   localparam int unsigned SNAP_W   = 192;
   localparam int unsigned IDX_W    = 5;
   localparam logic [IDX_W-1:0] LAST_IDX = 5'd23;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, SEND_HDR, SEND_PAY, SEND_CSUM} state_t;

   state_t             state;
   logic [SNAP_W-1:0]  snap;
   logic [IDX_W-1:0]   byte_idx;
   logic [7:0]         checksum;
   logic               trigger_q;
   logic               trig_edge;
   logic               accept;
   logic [7:0]         csum_next;

   assign trig_edge = trigger & ~trigger_q;
   assign accept    = tx_valid & tx_ready;
   assign csum_next = checksum ^ tx_data;

   // Snapshot byte selector: byte 0 is the MSB of icache_request.
   function automatic logic [7:0] snap_byte(input logic [IDX_W-1:0] idx);
      logic [SNAP_W-1:0] sh;
      sh = snap << {idx, 3'b000};
      return sh[SNAP_W-1 -: 8];
   endfunction

   // Frame FSM with registered stream outputs, frame and drop statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         tx_valid      <= 1'b0;
         tx_data       <= 8'h00;
         busy          <= 1'b0;
         frame_count   <= '0;
         dropped_count <= '0;
         snap          <= '0;
         byte_idx      <= '0;
         checksum      <= 8'h00;
         trigger_q     <= 1'b0;
      end else begin
         trigger_q <= trigger;
         if (!enable) begin
            // Abort drops the partial frame; statistics and snapshot stay.
            state    <= IDLE;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            byte_idx <= '0;
         end else begin
            if (trig_edge && (state != IDLE) && (dropped_count != CNT_MAX))
               dropped_count <= dropped_count + CNT_ONE;
            case (state)
               IDLE: begin
                  if (trig_edge) begin
                     snap     <= {icache_request_counter, icache_hit_counter,
                                  icache_miss_counter, dcache_request_counter,
                                  dcache_hit_counter, dcache_miss_counter};
                     byte_idx <= '0;
                     checksum <= 8'h00;
                     tx_data  <= HEADER_BYTE;
                     tx_valid <= 1'b1;
                     busy     <= 1'b1;
                     state    <= SEND_HDR;
                  end
               end
               SEND_HDR: begin
                  if (accept) begin
                     tx_data <= snap_byte(byte_idx);
                     state   <= SEND_PAY;
                  end
               end
               SEND_PAY: begin
                  if (accept) begin
                     checksum <= csum_next;
                     byte_idx <= byte_idx + 5'd1;
                     if (byte_idx == LAST_IDX) begin
                        tx_data <= csum_next;
                        state   <= SEND_CSUM;
                     end else begin
                        tx_data <= snap_byte(byte_idx + 5'd1);
                     end
                  end
               end
               SEND_CSUM: begin
                  if (accept) begin
                     tx_valid    <= 1'b0;
                     busy        <= 1'b0;
                     frame_count <= frame_count + CNT_ONE;
                     state       <= IDLE;
                  end
               end
               default: begin
                  state    <= IDLE;
                  tx_valid <= 1'b0;
                  busy     <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/cache_profile_reporter.md
Name: cache_profile_reporter

Overview:
- Downstream consumer of the cache profiler's six 32-bit counters (icache request/hit/miss, dcache request/hit/miss).
- On a trigger rising edge, it snapshots all six counters in one cycle and serialises them as a fixed 26-byte frame over a valid/ready byte stream to the UART transmitter.
- Frame layout: header, 24 payload bytes, XOR checksum.
- Also keeps frame and dropped-trigger statistics.

Parameters:
- HEADER_BYTE, 8'hA5, first byte of every frame.
- CNT_W, 16, width of the frame_count and dropped_count outputs.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- enable  in  1  block enable; low = synchronous abort to IDLE
- trigger  in  1  level input; a rising edge requests a report
- icache_request_counter  in  32  from profiler
- icache_hit_counter  in  32  from profiler
- icache_miss_counter  in  32  from profiler
- dcache_request_counter  in  32  from profiler
- dcache_hit_counter  in  32  from profiler
- dcache_miss_counter  in  32  from profiler
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte when tx_valid&tx_ready at posedge
- busy  out  1  high whenever state != IDLE
- frame_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W
- dropped_count  out  CNT_W  trigger edges ignored while busy, saturates at all-ones

Behaviour:
Reset (async, rst high):
- state=IDLE; tx_valid=0, tx_data=0, busy=0.
- frame_count=0, dropped_count=0.
- Snapshot registers = 0, checksum = 0, trigger_q = 0.

Edge detect:
- trigger_q <= trigger every cycle, including while enable is low.
- edge = trigger & ~trigger_q.
- Raising trigger while enable is low must not produce a report once enable returns with trigger still high.

FSM states: IDLE, SEND_HDR, SEND_PAY, SEND_CSUM.
- IDLE:
  - If enable & edge at posedge N: capture all six inputs into the snapshot, byte_idx=0, checksum=0, go to SEND_HDR.
  - From cycle N+1: tx_valid=1, tx_data=HEADER_BYTE.
- SEND_HDR: on accept, go to SEND_PAY.
- SEND_PAY:
  - Presents snapshot byte byte_idx (0..23).
  - Word order: icache_request, icache_hit, icache_miss, dcache_request, dcache_hit, dcache_miss.
  - Byte order: each word MSB first.
  - On each accept: checksum ^= byte, byte_idx++.
  - On accept of byte_idx 23: go to SEND_CSUM.
- SEND_CSUM:
  - Presents the XOR of the 24 payload bytes; the header is excluded.
  - On accept: go to IDLE, tx_valid=0 next cycle, frame_count++.

Handshake rules:
- tx_data and tx_valid are registered.
- While tx_valid=1 and tx_ready=0, tx_data holds stable.
- With tx_ready held high, one byte transfers per cycle. A full frame takes 26 cycles from the first tx_valid to the last accept.
- tx_valid never drops without an accept, except on abort (enable low) or rst.

Snapshot:
- Payload uses only the captured values.
- Input counter changes during a frame have no effect on the frame in progress.

Triggers while busy:
- An edge with state != IDLE increments dropped_count, saturating at 2^CNT_W-1.
- This includes the cycle in which the checksum is accepted.
- The dropped edge is not queued.
- An edge in the first IDLE cycle after a frame completes starts a new frame.

Enable low:
- Synchronous abort at the next posedge: state=IDLE, tx_valid=0, byte_idx=0.
- The partial frame is not counted in frame_count.
- frame_count, dropped_count and the snapshot are retained.
- Edges seen while enable is low are neither reported nor counted as dropped.

Reset mid-frame:
- Immediate return to the reset values above; tx_valid falls asynchronously.

Test Plan:
1. Counters 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10, 0x11121314, 0x15161718; tx_ready=1; pulse trigger -> stream A5, 01,02,...,18 (24 bytes), checksum 0x18; tx_valid 26 consecutive cycles starting the cycle after the edge; frame_count=1; busy low after the last accept.
2. Same frame with tx_ready toggling 1-0-1-0 and held low 5 cycles mid-payload -> tx_data stable while stalled; byte sequence identical to scenario 1; no duplicates or skips.
3. Change all counter inputs to 0xFFFFFFFF two cycles after the trigger -> frame still carries the scenario-1 values and checksum 0x18.
4. Three extra trigger pulses during a frame, plus one in the checksum-accept cycle -> dropped_count=4, exactly one frame sent; a pulse one cycle after busy falls starts frame 2 (frame_count=2).
5. Drop enable after payload byte 10 is accepted -> tx_valid=0 next cycle, state IDLE, frame_count unchanged. Raise trigger while enable is low, then re-enable with trigger held high -> no frame. Next fresh edge -> complete frame starting with A5.
6. Assert rst asynchronously mid-payload -> tx_valid=0 immediately; frame_count=0, dropped_count=0. Force dropped_count near saturation (CNT_W=4, 16 dropped edges) -> dropped_count stays at 0xF.
